// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback path.
package rv_wb_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } wb_req_t;

   // Round-robin successor of a granted index, wrapping at n.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found searching from ptr upward with wrap-around.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant
);

   logic found;
   int   idx;

   // Priority search starting at ptr; stops at the first valid requester.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port, with a
// pending-write scoreboard for RAW/WAW hazard detection.
// Optional build macro: RF_WB_BYPASS_EN forwards the in-flight write
// (rf_wd) to a matching read port and suppresses its hazard.
module regfile_wb_arbiter
   import rv_wb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int XLEN    = rv_wb_pkg::XLEN
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*5-1:0]    req_addr,
   input  logic [NUM_REQ*XLEN-1:0] req_data,
   output logic                    rf_we,
   output logic [4:0]              rf_wa,
   output logic [XLEN-1:0]         rf_wd,
   input  logic                    claim_valid,
   input  logic [4:0]              claim_addr,
   output logic                    claim_ready,
   input  logic [4:0]              ra1,
   input  logic [4:0]              ra2,
   input  logic [XLEN-1:0]         rf_rd1,
   input  logic [XLEN-1:0]         rf_rd2,
   output logic [XLEN-1:0]         rd1,
   output logic [XLEN-1:0]         rd2,
   output logic                    hazard1,
   output logic                    hazard2
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]    grant;
   logic [PTR_W-1:0]      rr_ptr;
   logic [PTR_W-1:0]      grant_idx;
   logic                  accept;
   logic [4:0]            sel_addr;
   logic [XLEN-1:0]       sel_data;
   logic                  we_q;
   logic [NUM_REGS-1:0]   pending;
   logic [NUM_REGS-1:0]   pending_nxt;
   logic                  claim_fire;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_arbiter (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (grant)
   );

   // Grant is already qualified by req_valid, so any grant is an accept.
   assign req_ready = grant;
   assign accept    = |grant;

   // Encode the winner and select its address/data.
   always_comb begin
      grant_idx = '0;
      sel_addr  = '0;
      sel_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            grant_idx = PTR_W'(i);
            sel_addr  = req_addr[5*i +: 5];
            sel_data  = req_data[XLEN*i +: XLEN];
         end
      end
   end

   // Pointer moves just past the winner on every accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= PTR_W'(rr_next(int'(grant_idx), NUM_REQ));
      end
   end

   // Registered write stage; x0 writes are consumed but never enabled.
   always_ff @(posedge clk) begin
      if (reset) begin
         we_q  <= 1'b0;
         rf_wa <= '0;
         rf_wd <= '0;
      end else if (accept) begin
         we_q  <= (sel_addr != 5'd0);
         rf_wa <= sel_addr;
         rf_wd <= sel_data;
      end else begin
         we_q  <= 1'b0;
      end
   end

   // Reset kills a write already sitting in the stage so it never lands.
   assign rf_we = we_q && !reset;

   assign claim_ready = (claim_addr == 5'd0) || !pending[claim_addr];
   assign claim_fire  = claim_valid && claim_ready && (claim_addr != 5'd0);

   // Clear on retire first, then set on claim so a same-edge claim wins.
   always_comb begin
      pending_nxt = pending;
      if (rf_we) begin
         pending_nxt[rf_wa] = 1'b0;
      end
      if (claim_fire) begin
         pending_nxt[claim_addr] = 1'b1;
      end
      pending_nxt[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= '0;
      end else begin
         pending <= pending_nxt;
      end
   end

`ifdef RF_WB_BYPASS_EN
   // Forward the write in flight to a matching read port.
   always_comb begin
      rd1     = rf_rd1;
      hazard1 = pending[ra1];
      rd2     = rf_rd2;
      hazard2 = pending[ra2];
      if (rf_we && (rf_wa == ra1) && (ra1 != 5'd0)) begin
         rd1     = rf_wd;
         hazard1 = 1'b0;
      end
      if (rf_we && (rf_wa == ra2) && (ra2 != 5'd0)) begin
         rd2     = rf_wd;
         hazard2 = 1'b0;
      end
   end
`else
   // No forwarding: a hazard holds until the write has landed.
   always_comb begin
      rd1     = rf_rd1;
      hazard1 = pending[ra1];
      rd2     = rf_rd2;
      hazard2 = pending[ra2];
   end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a behavioural register file.
module tb_regfile_wb_arbiter;

   localparam int NUM_REQ = 2;
   localparam int XLEN    = 32;

   logic                    clk;
   logic                    reset;
   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ-1:0]      req_ready;
   logic [NUM_REQ*5-1:0]    req_addr;
   logic [NUM_REQ*XLEN-1:0] req_data;
   logic                    rf_we;
   logic [4:0]              rf_wa;
   logic [XLEN-1:0]         rf_wd;
   logic                    claim_valid;
   logic [4:0]              claim_addr;
   logic                    claim_ready;
   logic [4:0]              ra1;
   logic [4:0]              ra2;
   logic [XLEN-1:0]         rf_rd1;
   logic [XLEN-1:0]         rf_rd2;
   logic [XLEN-1:0]         rd1;
   logic [XLEN-1:0]         rd2;
   logic                    hazard1;
   logic                    hazard2;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [XLEN-1:0] regs [32];

   regfile_wb_arbiter #(
      .NUM_REQ (NUM_REQ),
      .XLEN    (XLEN)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .rf_we       (rf_we),
      .rf_wa       (rf_wa),
      .rf_wd       (rf_wd),
      .claim_valid (claim_valid),
      .claim_addr  (claim_addr),
      .claim_ready (claim_ready),
      .ra1         (ra1),
      .ra2         (ra2),
      .rf_rd1      (rf_rd1),
      .rf_rd2      (rf_rd2),
      .rd1         (rd1),
      .rd2         (rd2),
      .hazard1     (hazard1),
      .hazard2     (hazard2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model: synchronous write, asynchronous read, x0 hardwired.
   always @(posedge clk) begin
      if (rf_we && rf_wa != 5'd0) regs[rf_wa] <= rf_wd;
   end
   assign rf_rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
   assign rf_rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [4:0] a, input logic [XLEN-1:0] d);
      req_addr[5*i +: 5]       = a;
      req_data[XLEN*i +: XLEN] = d;
   endtask

   task automatic idle_inputs();
      req_valid   = '0;
      req_addr    = '0;
      req_data    = '0;
      claim_valid = 1'b0;
      claim_addr  = '0;
      ra1         = '0;
      ra2         = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      ra1 = 5'd5;
      claim_addr = 5'd5;
      #1;
      total_cnt++;
      if (rf_we !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 32'h0)
         $display("FAIL reset_wstage: we=%b wa=%0d wd=%h required 0/0/0", rf_we, rf_wa, rf_wd);
      else pass_cnt++;
      total_cnt++;
      if (req_ready !== 2'b00)
         $display("FAIL reset_ready_idle: got %b required 00", req_ready);
      else pass_cnt++;
      total_cnt++;
      if (hazard1 !== 1'b0 || claim_ready !== 1'b1)
         $display("FAIL reset_scoreboard: hazard1=%b claim_ready=%b required 0/1", hazard1, claim_ready);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_write();
      do_reset();
      claim_valid = 1'b1;
      claim_addr  = 5'd5;
      tick();
      claim_valid = 1'b0;
      req_valid = 2'b01;
      set_req(0, 5'd5, 32'hDEAD_BEEF);
      tick();
      req_valid = 2'b00;
      reset = 1'b1;
      #1;
      total_cnt++;
      if (rf_we !== 1'b0)
         $display("FAIL midwrite_we_in_reset: got %b required 0", rf_we);
      else pass_cnt++;
      tick();
      reset = 1'b0;
      ra1 = 5'd5;
      #1;
      total_cnt++;
      if (rf_we !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 32'h0)
         $display("FAIL midwrite_wstage: we=%b wa=%0d wd=%h required 0/0/0", rf_we, rf_wa, rf_wd);
      else pass_cnt++;
      total_cnt++;
      if (hazard1 !== 1'b0 || rd1 !== 32'h0)
         $display("FAIL midwrite_x5: hazard1=%b rd1=%h required 0/00000000", hazard1, rd1);
      else pass_cnt++;
      req_valid = 2'b11;
      set_req(0, 5'd1, 32'h1);
      set_req(1, 5'd2, 32'h2);
      #1;
      total_cnt++;
      if (req_ready !== 2'b01)
         $display("FAIL midwrite_ptr: got %b required 01", req_ready);
      else pass_cnt++;
      req_valid = 2'b00;
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_ready;
      logic [4:0] exp_wa;
      logic [31:0] exp_wd;
      do_reset();
      set_req(0, 5'd1, 32'h0000_0100);
      set_req(1, 5'd2, 32'h0000_0200);
      req_valid = 2'b11;
      exp_ready = 2'b01;
      for (int k = 0; k < 4; k++) begin
         #1;
         total_cnt++;
         if (req_ready !== exp_ready)
            $display("FAIL rr_grant[%0d]: got %b required %b", k, req_ready, exp_ready);
         else pass_cnt++;
         exp_wa = exp_ready[0] ? 5'd1 : 5'd2;
         exp_wd = exp_ready[0] ? 32'h100 : 32'h200;
         tick();
         total_cnt++;
         if (rf_we !== 1'b1 || rf_wa !== exp_wa || rf_wd !== exp_wd)
            $display("FAIL rr_write[%0d]: we=%b wa=%0d wd=%h required 1/%0d/%h",
                     k, rf_we, rf_wa, rf_wd, exp_wa, exp_wd);
         else pass_cnt++;
         exp_ready = ~exp_ready;
      end
      req_valid = 2'b10;
      for (int k = 0; k < 3; k++) begin
         #1;
         total_cnt++;
         if (req_ready !== 2'b10)
            $display("FAIL rr_only1[%0d]: got %b required 10", k, req_ready);
         else pass_cnt++;
         tick();
      end
      req_valid = 2'b00;
      tick();
      total_cnt++;
      if (rf_we !== 1'b0 || rf_wa !== 5'd2 || rf_wd !== 32'h200)
         $display("FAIL rr_hold: we=%b wa=%0d wd=%h required 0/2/00000200", rf_we, rf_wa, rf_wd);
      else pass_cnt++;
   endtask

   task automatic test_x0_drop();
      do_reset();
      req_valid = 2'b01;
      set_req(0, 5'd0, 32'h1234);
      ra1 = 5'd0;
      #1;
      total_cnt++;
      if (req_ready !== 2'b01)
         $display("FAIL x0_ready: got %b required 01", req_ready);
      else pass_cnt++;
      tick();
      req_valid = 2'b00;
      #1;
      total_cnt++;
      if (rf_we !== 1'b0)
         $display("FAIL x0_we: got %b required 0", rf_we);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (rd1 !== 32'h0 || hazard1 !== 1'b0)
         $display("FAIL x0_read: rd1=%h hazard1=%b required 0/0", rd1, hazard1);
      else pass_cnt++;
   endtask

   task automatic test_claim_hazard();
      do_reset();
      claim_valid = 1'b1;
      claim_addr  = 5'd7;
      ra1 = 5'd7;
      ra2 = 5'd7;
      #1;
      total_cnt++;
      if (claim_ready !== 1'b1)
         $display("FAIL claim7_ready: got %b required 1", claim_ready);
      else pass_cnt++;
      tick();
      claim_valid = 1'b0;
      #1;
      total_cnt++;
      if (hazard1 !== 1'b1 || hazard2 !== 1'b1)
         $display("FAIL claim7_hazard: h1=%b h2=%b required 1/1", hazard1, hazard2);
      else pass_cnt++;
      tick();
      tick();
      req_valid = 2'b10;
      set_req(1, 5'd7, 32'hA5A5_0001);
      tick();
      req_valid = 2'b00;
      #1;
      total_cnt++;
`ifdef RF_WB_BYPASS_EN
      if (rf_we !== 1'b1 || hazard1 !== 1'b0 || rd1 !== 32'hA5A5_0001 || hazard2 !== 1'b0)
         $display("FAIL bypass_c4: we=%b h1=%b rd1=%h h2=%b required 1/0/a5a50001/0",
                  rf_we, hazard1, rd1, hazard2);
      else pass_cnt++;
`else
      if (rf_we !== 1'b1 || hazard1 !== 1'b1 || hazard2 !== 1'b1)
         $display("FAIL nobypass_c4: we=%b h1=%b h2=%b required 1/1/1", rf_we, hazard1, hazard2);
      else pass_cnt++;
`endif
      tick();
      total_cnt++;
      if (hazard1 !== 1'b0 || rd1 !== 32'hA5A5_0001 || hazard2 !== 1'b0 || rd2 !== 32'hA5A5_0001)
         $display("FAIL claim7_c5: h1=%b rd1=%h h2=%b rd2=%h required 0/a5a50001/0/a5a50001",
                  hazard1, rd1, hazard2, rd2);
      else pass_cnt++;
   endtask

   task automatic test_waw_set_clear();
      do_reset();
      claim_valid = 1'b1;
      claim_addr  = 5'd9;
      ra1 = 5'd9;
      tick();
      #1;
      total_cnt++;
      if (claim_ready !== 1'b0)
         $display("FAIL waw_stall: got %b required 0", claim_ready);
      else pass_cnt++;
      tick();
      claim_valid = 1'b0;
      req_valid = 2'b01;
      set_req(0, 5'd9, 32'h0000_0099);
      tick();
      req_valid = 2'b00;
      tick();
      total_cnt++;
      if (hazard1 !== 1'b0 || claim_ready !== 1'b1)
         $display("FAIL waw_cleared: h1=%b claim_ready=%b required 0/1", hazard1, claim_ready);
      else pass_cnt++;
      req_valid = 2'b01;
      set_req(0, 5'd9, 32'h0000_0999);
      tick();
      req_valid = 2'b00;
      claim_valid = 1'b1;
      claim_addr  = 5'd9;
      #1;
      total_cnt++;
      if (rf_we !== 1'b1 || rf_wa !== 5'd9 || claim_ready !== 1'b1)
         $display("FAIL setclr_pre: we=%b wa=%0d claim_ready=%b required 1/9/1", rf_we, rf_wa, claim_ready);
      else pass_cnt++;
      tick();
      claim_valid = 1'b0;
      #1;
      total_cnt++;
      if (hazard1 !== 1'b1 || claim_ready !== 1'b0 || rd1 !== 32'h0000_0999)
         $display("FAIL setclr_wins: h1=%b claim_ready=%b rd1=%h required 1/0/00000999",
                  hazard1, claim_ready, rd1);
      else pass_cnt++;
   endtask

   initial begin
      for (int r = 0; r < 32; r++) regs[r] = '0;
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_reset_mid_write();
      test_round_robin();
      test_x0_drop();
      test_claim_hazard();
      test_waw_set_clear();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
